// File: rtl/stepper_pkg.sv
// stepper_pkg: shared types and helpers for the microstepping stepper driver.
//   state_e        : drive state (IDLE / RUN)
//   COIL_A..COIL_D : bit positions of each coil inside the 4-bit pin vector
//   COS_TABLE      : 8-bit cosine duty levels for quarter-phase indices 0..4
//   phase_duties() : maps a phase index to the four coil duties (packed [3:0][7:0])
package stepper_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int COIL_A = 3;
  localparam int COIL_B = 2;
  localparam int COIL_C = 1;
  localparam int COIL_D = 0;

  localparam logic [7:0] DUTY_FULL = 8'd255;
  localparam logic [7:0] DUTY_OFF  = 8'd0;

  localparam logic [7:0] COS_TABLE [0:4] = '{8'd255, 8'd236, 8'd180, 8'd98, 8'd0};

  // The lead coil (bit 3-q) sits at COS[s*4/M] and fades out as s grows; the
  // following coil (bit 3-(q+1)) mirrors it at COS[(M-s)*4/M]. Scaling by 4/M
  // lets one 5-entry table serve every microstep resolution.
  function automatic logic [3:0][7:0] phase_duties(input logic [3:0] p,
                                                   input int unsigned micro_log2);
    logic [3:0][7:0] duty;
    logic [3:0]      m;
    logic [3:0]      s;
    logic [1:0]      q;
    logic [1:0]      lead;
    logic [1:0]      nxt;
    logic [2:0]      stp;
    logic [2:0]      idx_lead;
    logic [2:0]      idx_next;
    m        = 4'(1 << micro_log2);
    q        = 2'(p >> micro_log2);
    s        = p & (m - 4'd1);
    stp      = 3'(4 >> micro_log2);
    lead     = 2'(COIL_A) - q;
    nxt      = 2'(COIL_A) - (q + 2'd1);
    idx_lead = 3'(s * stp);
    idx_next = 3'((m - s) * stp);
    duty       = '0;
    duty[lead] = COS_TABLE[idx_lead];
    duty[nxt]  = COS_TABLE[idx_next];
    return duty;
  endfunction

endpackage

// File: rtl/stepper_microstep_drive_coil_pwm.sv
// coil_pwm: per-coil PWM comparator against the shared free-running counter.
//   duty : 8-bit duty level (255 = constant on, 0 = constant off)
//   pc   : shared 8-bit PWM counter
//   coil : PWM output for this coil
module coil_pwm
  import stepper_pkg::*;
(
  input  logic [7:0] duty,
  input  logic [7:0] pc,
  output logic       coil
);

  always_comb begin
    if (duty == DUTY_FULL) begin
      coil = 1'b1;
    end else if (duty == DUTY_OFF) begin
      coil = 1'b0;
    end else begin
      coil = (pc < duty);
    end
  end

endmodule

// File: rtl/stepper_microstep_drive.sv
// stepper_microstep_drive: microstepping driver for a 4-wire unipolar stepper.
// Accepts move commands over valid/ready, steps the coil phase at the commanded
// rate, tracks signed absolute position and drives each coil through its own PWM.
// Ports:
//   clock, reset_n (sync, active-low)
//   cmd_valid/cmd_ready handshake; cmd_dir, cmd_steps, cmd_period sampled on accept
//   abort       : ends a running move (ignored when idle)
//   hold_en     : idle coils at half current (1) or released (0)
//   busy, done  : move in progress / one-cycle end-of-move pulse
//   position    : signed microstep position, wraps
//   stepperPins : coil drive, bit 3 = A .. bit 0 = D
module stepper_microstep_drive
  import stepper_pkg::*;
#(
  parameter int MICRO_LOG2  = 2,
  parameter int PERIOD_BITS = 24,
  parameter int COUNT_BITS  = 16,
  parameter int POS_BITS    = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_dir,
  input  logic [COUNT_BITS-1:0]      cmd_steps,
  input  logic [PERIOD_BITS-1:0]     cmd_period,
  input  logic                       abort,
  input  logic                       hold_en,
  output logic                       busy,
  output logic                       done,
  output logic signed [POS_BITS-1:0] position,
  output logic [3:0]                 stepperPins
);

  localparam int PHASE_W = MICRO_LOG2 + 2;

  function automatic logic [7:0] half_current(input logic [7:0] d);
    return d >> 1;
  endfunction

  state_e                       state;
  logic                         ready_en;
  logic                         done_q;
  logic [PHASE_W-1:0]           phase_q;
  logic signed [POS_BITS-1:0]   position_q;
  logic [7:0]                   pc_q;
  logic [3:0]                   pins_p1;

  logic [PERIOD_BITS-1:0]       timer_q;
  logic [PERIOD_BITS-1:0]       reload_q;
  logic [COUNT_BITS-1:0]        remaining_q;
  logic                         dir_q;

  logic                         accept;
  logic                         step_due;
  logic                         last_step;
  logic [PERIOD_BITS-1:0]       period_m1;

  logic [3:0][7:0]              duty_full;
  logic [3:0][7:0]              duty_p0;
  logic [3:0]                   pwm_bits;

  assign busy        = (state == RUN);
  assign cmd_ready   = ready_en & ~busy;
  assign done        = done_q;
  assign position    = position_q;
  assign stepperPins = pins_p1;

  assign accept    = cmd_valid & cmd_ready;
  assign step_due  = busy & (timer_q == '0);
  assign last_step = (remaining_q == COUNT_BITS'(1));
  // A zero period behaves as one microstep per cycle.
  assign period_m1 = (cmd_period == '0) ? '0 : cmd_period - 1'b1;

  // ---- stage p0: phase -> coil duties -> PWM compare ----
  always_comb begin
    duty_full = phase_duties(4'(phase_q), MICRO_LOG2);
    duty_p0   = '0;
    for (int i = 0; i < 4; i++) begin
      if (busy) begin
        duty_p0[i] = duty_full[i];
      end else if (hold_en) begin
        duty_p0[i] = half_current(duty_full[i]);
      end else begin
        duty_p0[i] = DUTY_OFF;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_coil
    coil_pwm u_coil_pwm (
      .duty (duty_p0[g]),
      .pc   (pc_q),
      .coil (pwm_bits[g])
    );
  end

  // ---- stage p1: registered control, counters and coil pins ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      ready_en   <= 1'b0;
      done_q     <= 1'b0;
      phase_q    <= '0;
      position_q <= '0;
      pc_q       <= '0;
      pins_p1    <= '0;
    end else begin
      ready_en <= 1'b1;
      done_q   <= 1'b0;
      pc_q     <= pc_q + 8'd1;
      pins_p1  <= pwm_bits;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_steps == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // Abort wins over a microstep falling due on the same edge.
          if (abort) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else if (step_due) begin
            phase_q    <= dir_q ? phase_q + 1'b1 : phase_q - 1'b1;
            position_q <= dir_q ? position_q + 1'b1 : position_q - 1'b1;
            if (last_step) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Move parameters: only meaningful while RUN, loaded on every accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      timer_q     <= period_m1;
      reload_q    <= period_m1;
      remaining_q <= cmd_steps;
      dir_q       <= cmd_dir;
    end else if (busy) begin
      if (timer_q == '0) begin
        timer_q     <= reload_q;
        remaining_q <= remaining_q - 1'b1;
      end else begin
        timer_q <= timer_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stepper_microstep_drive.sv
module tb_stepper_microstep_drive;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_valid0;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [23:0] cmd_period;
  logic        abort;
  logic        hold_en;

  logic               cmd_ready, busy, done;
  logic signed [15:0] position;
  logic [3:0]         stepperPins;

  logic               cmd_ready0, busy0, done0;
  logic signed [15:0] position0;
  logic [3:0]         pins0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  stepper_microstep_drive #(
    .MICRO_LOG2(2), .PERIOD_BITS(24), .COUNT_BITS(16), .POS_BITS(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .hold_en(hold_en), .busy(busy), .done(done), .position(position),
    .stepperPins(stepperPins)
  );

  stepper_microstep_drive #(
    .MICRO_LOG2(0), .PERIOD_BITS(24), .COUNT_BITS(16), .POS_BITS(16)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .hold_en(hold_en), .busy(busy0), .done(done0), .position(position0),
    .stepperPins(pins0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input bit sel0, input logic dir, input logic [15:0] steps,
                       input logic [23:0] period);
    check(sel0 ? "ready0_before_issue" : "ready_before_issue",
          sel0 ? {31'd0, cmd_ready0} : {31'd0, cmd_ready}, 32'd1);
    cmd_dir    = dir;
    cmd_steps  = steps;
    cmd_period = period;
    if (sel0) cmd_valid0 = 1'b1;
    else      cmd_valid  = 1'b1;
    @(negedge clock);
    cmd_valid  = 1'b0;
    cmd_valid0 = 1'b0;
  endtask

  task automatic run_move(input string tag, input logic dir, input logic [15:0] steps,
                          input logic [23:0] period, input int exp_cycles, input int exp_first);
    int          cnt;
    int          first;
    int          dc;
    logic [15:0] start;
    cnt   = 0;
    first = -1;
    dc    = 0;
    start = position;
    issue(1'b0, dir, steps, period);
    while (busy === 1'b1 && cnt < exp_cycles + 50) begin
      if (done === 1'b1) dc++;
      if (first < 0 && position !== start) first = cnt;
      cnt++;
      @(negedge clock);
    end
    check({tag, "_busy_cycles"}, cnt, exp_cycles);
    check({tag, "_first_step"}, first, exp_first);
    check({tag, "_done_during_busy"}, dc, 0);
    check({tag, "_done_at_end"}, {31'd0, done}, 32'd1);
    @(negedge clock);
    check({tag, "_done_single"}, {31'd0, done}, 32'd0);
  endtask

  task automatic measure(output int a, output int b, output int c, output int d);
    a = 0; b = 0; c = 0; d = 0;
    for (int i = 0; i < 256; i++) begin
      a += int'(stepperPins[3]);
      b += int'(stepperPins[2]);
      c += int'(stepperPins[1]);
      d += int'(stepperPins[0]);
      @(negedge clock);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, c, d, cnt, dc;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_valid0 = 1'b0;
    cmd_dir    = 1'b1;
    cmd_steps  = '0;
    cmd_period = '0;
    abort      = 1'b0;
    hold_en    = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_position", $unsigned(position), 32'd0);
    check("rst_pins", {28'd0, stepperPins}, 32'd0);

    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    check("ready0_after_reset", {31'd0, cmd_ready0}, 32'd1);

    // Reverse with wrap, period 0 -> one microstep per cycle; p = 15,14,13.
    run_move("rev", 1'b0, 16'd3, 24'd0, 3, 1);
    check("rev_position", $unsigned(position), 32'h0000FFFD);
    hold_en = 1'b1;
    repeat (2) @(negedge clock);
    measure(a, b, c, d);
    check("hold_p13_A", a, 49);
    check("hold_p13_B", b, 0);
    check("hold_p13_C", c, 0);
    check("hold_p13_D", d, 118);
    hold_en = 1'b0;

    run_move("fwd3", 1'b1, 16'd3, 24'd0, 3, 1);
    check("fwd3_position", $unsigned(position), 32'd0);

    // Full electrical cycle forward.
    run_move("full", 1'b1, 16'd16, 24'd4, 64, 4);
    check("full_position", $unsigned(position), 32'd16);
    hold_en = 1'b1;
    repeat (2) @(negedge clock);
    measure(a, b, c, d);
    check("hold_p0_A", a, 127);
    check("hold_p0_B", b, 0);
    check("hold_p0_C", c, 0);
    check("hold_p0_D", d, 0);
    hold_en = 1'b0;
    repeat (2) @(negedge clock);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cnt += int'(|stepperPins);
      @(negedge clock);
    end
    check("release_pins_zero", cnt, 0);

    // Duties at p=1 while running: A=236, B=98.
    issue(1'b0, 1'b1, 16'd2, 24'd300);
    repeat (310) @(negedge clock);
    measure(a, b, c, d);
    check("run_p1_A", a, 236);
    check("run_p1_B", b, 98);
    check("run_p1_C", c, 0);
    check("run_p1_D", d, 0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      @(negedge clock);
    end
    check("p1move_done", {31'd0, done}, 32'd1);
    check("p1move_position", $unsigned(position), 32'd18);
    @(negedge clock);

    // Zero-length command.
    issue(1'b0, 1'b1, 16'd0, 24'd5);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    @(negedge clock);
    check("zero_done_clear", {31'd0, done}, 32'd0);
    check("zero_position", $unsigned(position), 32'd18);

    // Abort sampled 55 cycles after accept.
    issue(1'b0, 1'b1, 16'd100, 24'd10);
    repeat (54) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort55_busy", {31'd0, busy}, 32'd0);
    check("abort55_done", {31'd0, done}, 32'd1);
    check("abort55_position", $unsigned(position), 32'd23);
    check("abort55_ready", {31'd0, cmd_ready}, 32'd1);

    // Back-to-back accept in the done cycle; abort lands on a due microstep.
    issue(1'b0, 1'b1, 16'd100, 24'd10);
    repeat (59) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    check("abort60_busy", {31'd0, busy}, 32'd0);
    check("abort60_done", {31'd0, done}, 32'd1);
    check("abort60_position", $unsigned(position), 32'd28);

    // Abort while idle has no effect.
    @(negedge clock);
    @(negedge clock);
    check("idle_abort_done", {31'd0, done}, 32'd0);
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    check("idle_abort_position", $unsigned(position), 32'd28);
    abort = 1'b0;

    // Reset in the middle of a move.
    issue(1'b0, 1'b1, 16'd50, 24'd3);
    repeat (20) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd0);
    check("midrst_position", $unsigned(position), 32'd0);
    check("midrst_pins", {28'd0, stepperPins}, 32'd0);
    reset_n = 1'b1;
    dc = 0;
    repeat (4) begin
      @(negedge clock);
      dc += int'(done);
    end
    check("midrst_no_done", dc, 0);
    check("midrst_ready_back", {31'd0, cmd_ready}, 32'd1);

    // Full-step build: A, B, C, D each fully on.
    issue(1'b1, 1'b1, 16'd4, 24'd3);
    repeat (2) @(negedge clock);
    check("full_step_A", {28'd0, pins0}, 32'b1000);
    repeat (3) @(negedge clock);
    check("full_step_B", {28'd0, pins0}, 32'b0100);
    repeat (3) @(negedge clock);
    check("full_step_C", {28'd0, pins0}, 32'b0010);
    repeat (3) @(negedge clock);
    check("full_step_D", {28'd0, pins0}, 32'b0001);
    @(negedge clock);
    check("full_step_busy", {31'd0, busy0}, 32'd0);
    check("full_step_done", {31'd0, done0}, 32'd1);
    check("full_step_position", $unsigned(position0), 32'd4);
    repeat (2) @(negedge clock);
    check("full_step_released", {28'd0, pins0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
